// File: rtl/vec_csr_regs_pkg.sv
// Shared vector decode/CSR definitions.
// Contents: config FSM state encoding, vtype field positions, vsew/vlmul
// encodings and the position of the vill bit within an XLEN-wide vtype.
package vec_csr_regs_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StUpdate,
    StResp
  } cfg_state_e;

  typedef enum logic [2:0] {
    Sew8  = 3'd0,
    Sew16 = 3'd1,
    Sew32 = 3'd2,
    Sew64 = 3'd3
  } vsew_e;

  typedef enum logic [2:0] {
    Lmul1    = 3'd0,
    Lmul2    = 3'd1,
    Lmul4    = 3'd2,
    Lmul8    = 3'd3,
    LmulRsvd = 3'd4,
    LmulF8   = 3'd5,
    LmulF4   = 3'd6,
    LmulF2   = 3'd7
  } vlmul_e;

  // vtype field positions
  localparam int unsigned VlmulLsb = 0;
  localparam int unsigned VsewLsb  = 3;
  localparam int unsigned VtaBit   = 6;
  localparam int unsigned VmaBit   = 7;
  localparam int unsigned RsvdLsb  = 8;

  function automatic int unsigned vill_bit(input int unsigned xlen);
    return xlen - 1;
  endfunction

endpackage

// File: rtl/vec_vlmax_calc.sv
// Combinational vtype legality check and VLMAX computation.
// Ports:
//   vtype   - candidate vtype value (XLEN bits)
//   vlmax   - VLMAX for vtype, zero-extended to XLEN; 0 when illegal
//   illegal - vtype is not a supported configuration
module vec_vlmax_calc
  import vec_csr_regs_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned VLEN = 512,
  parameter int unsigned ELEN = 64
) (
  input  logic [XLEN-1:0] vtype,
  output logic [XLEN-1:0] vlmax,
  output logic            illegal
);

  localparam int unsigned VlmaxW = $clog2(VLEN) + 1;

  logic [2:0]        vlmul;
  logic [2:0]        vsew;
  logic              rsvd_set;
  logic [31:0]       sew_bits;
  logic [31:0]       elen_lim;
  logic [VlmaxW-1:0] base;
  logic [VlmaxW-1:0] scaled;

  // Tail/mask policy bits do not affect legality or VLMAX.
  logic unused_policy;
  assign unused_policy = vtype[VtaBit] ^ vtype[VmaBit];

  always_comb begin
    vlmul    = vtype[VlmulLsb +: 3];
    vsew     = vtype[VsewLsb +: 3];
    rsvd_set = |vtype[XLEN-1:RsvdLsb];
    sew_bits = 32'd8 << vsew;

    // Largest SEW allowed is ELEN * LMUL for fractional LMUL, ELEN otherwise.
    elen_lim = ELEN;
    case (vlmul)
      LmulF8:  elen_lim = ELEN >> 3;
      LmulF4:  elen_lim = ELEN >> 2;
      LmulF2:  elen_lim = ELEN >> 1;
      default: elen_lim = ELEN;
    endcase

    illegal = rsvd_set
            | (vsew > 3'(Sew64))
            | (vlmul == 3'(LmulRsvd))
            | (sew_bits > elen_lim);

    base = VlmaxW'(VLEN) >> ({1'b0, vsew} + 4'd3);
    if (vlmul[2]) begin
      // Fractional: 101 -> >>3, 110 -> >>2, 111 -> >>1
      scaled = base >> (4'd8 - {1'b0, vlmul});
    end else begin
      scaled = base << vlmul[1:0];
    end

    vlmax = illegal ? '0 : XLEN'(scaled);
  end

endmodule

// File: rtl/vec_csr_regs.sv
// Vector configuration CSR block.
// Captures vtype/AVL from vsetvl-family instructions, legality-checks vtype,
// clamps vl to VLMAX, holds architectural vtype/vl/vill and returns the new
// vl to the scalar rd through a valid/ready write-back port.
// Ports:
//   clk, reset                   - clock, synchronous active-high reset
//   cfg_valid_i / cfg_ready_o    - config request handshake from decode
//   vtype_i, vl_i, rd_addr_i     - requested vtype, AVL and destination rd
//   csr_vtype_o, csr_vl_o        - architectural vtype and vl
//   vill_o, vlmax_o              - vill bit and VLMAX of current vtype
//   rd_wr_valid_o / rd_wr_ready_i, rd_wr_addr_o, rd_wr_data_o - rd write-back
module vec_csr_regs
  import vec_csr_regs_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned VLEN = 512,
  parameter int unsigned ELEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cfg_valid_i,
  output logic            cfg_ready_o,
  input  logic [XLEN-1:0] vtype_i,
  input  logic [XLEN-1:0] vl_i,
  input  logic [4:0]      rd_addr_i,
  output logic [XLEN-1:0] csr_vtype_o,
  output logic [XLEN-1:0] csr_vl_o,
  output logic            vill_o,
  output logic [XLEN-1:0] vlmax_o,
  output logic            rd_wr_valid_o,
  output logic [4:0]      rd_wr_addr_o,
  output logic [XLEN-1:0] rd_wr_data_o,
  input  logic            rd_wr_ready_i
);

  localparam int unsigned     VillBit   = vill_bit(XLEN);
  localparam logic [XLEN-1:0] VtypeVill = XLEN'(1) << VillBit;

  cfg_state_e      state_q, state_d;
  logic [XLEN-1:0] stage_vtype_q, stage_vtype_d;
  logic [XLEN-1:0] stage_vl_q, stage_vl_d;
  logic [4:0]      stage_rd_q, stage_rd_d;
  logic [XLEN-1:0] csr_vtype_q, csr_vtype_d;
  logic [XLEN-1:0] csr_vl_q, csr_vl_d;

  logic [XLEN-1:0] stage_vlmax;
  logic            stage_illegal;
  logic            unused_csr_illegal;

  // Update path: checks the staged request.
  vec_vlmax_calc #(
    .XLEN(XLEN),
    .VLEN(VLEN),
    .ELEN(ELEN)
  ) u_calc_stage (
    .vtype  (stage_vtype_q),
    .vlmax  (stage_vlmax),
    .illegal(stage_illegal)
  );

  // Observation path: VLMAX of the architectural vtype. An illegal csr_vtype
  // is always the vill encoding, which already yields vlmax = 0.
  vec_vlmax_calc #(
    .XLEN(XLEN),
    .VLEN(VLEN),
    .ELEN(ELEN)
  ) u_calc_csr (
    .vtype  (csr_vtype_q),
    .vlmax  (vlmax_o),
    .illegal(unused_csr_illegal)
  );

  always_comb begin
    state_d       = state_q;
    stage_vtype_d = stage_vtype_q;
    stage_vl_d    = stage_vl_q;
    stage_rd_d    = stage_rd_q;
    csr_vtype_d   = csr_vtype_q;
    csr_vl_d      = csr_vl_q;

    case (state_q)
      StIdle: begin
        if (cfg_valid_i) begin
          stage_vtype_d = vtype_i;
          stage_vl_d    = vl_i;
          stage_rd_d    = rd_addr_i;
          state_d       = StUpdate;
        end
      end
      StUpdate: begin
        if (stage_illegal) begin
          csr_vtype_d = VtypeVill;
          csr_vl_d    = '0;
        end else begin
          csr_vtype_d = stage_vtype_q;
          csr_vl_d    = (stage_vl_q > stage_vlmax) ? stage_vlmax : stage_vl_q;
        end
        state_d = (stage_rd_q != 5'd0) ? StResp : StIdle;
      end
      StResp: begin
        if (rd_wr_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      stage_vtype_q <= '0;
      stage_vl_q    <= '0;
      stage_rd_q    <= '0;
      csr_vtype_q   <= VtypeVill;
      csr_vl_q      <= '0;
    end else begin
      state_q       <= state_d;
      stage_vtype_q <= stage_vtype_d;
      stage_vl_q    <= stage_vl_d;
      stage_rd_q    <= stage_rd_d;
      csr_vtype_q   <= csr_vtype_d;
      csr_vl_q      <= csr_vl_d;
    end
  end

  assign cfg_ready_o   = (state_q == StIdle);
  assign csr_vtype_o   = csr_vtype_q;
  assign csr_vl_o      = csr_vl_q;
  assign vill_o        = csr_vtype_q[VillBit];

  // The new vl is already in csr_vl_q while in RESP, so it doubles as the
  // write-back data and stays stable under back-pressure.
  assign rd_wr_valid_o = (state_q == StResp);
  assign rd_wr_addr_o  = rd_wr_valid_o ? stage_rd_q : 5'd0;
  assign rd_wr_data_o  = rd_wr_valid_o ? csr_vl_q : '0;

endmodule

// File: tb/tb_vec_csr_regs.sv
// Directed self-checking bench for vec_csr_regs (XLEN=32, VLEN=512, ELEN=64).
module tb_vec_csr_regs;

  logic        clk;
  logic        reset;
  logic        cfg_valid_i;
  logic        cfg_ready_o;
  logic [31:0] vtype_i;
  logic [31:0] vl_i;
  logic [4:0]  rd_addr_i;
  logic [31:0] csr_vtype_o;
  logic [31:0] csr_vl_o;
  logic        vill_o;
  logic [31:0] vlmax_o;
  logic        rd_wr_valid_o;
  logic [4:0]  rd_wr_addr_o;
  logic [31:0] rd_wr_data_o;
  logic        rd_wr_ready_i;

  int passed = 0;
  int total  = 0;

  vec_csr_regs #(
    .XLEN(32),
    .VLEN(512),
    .ELEN(64)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_valid_i  (cfg_valid_i),
    .cfg_ready_o  (cfg_ready_o),
    .vtype_i      (vtype_i),
    .vl_i         (vl_i),
    .rd_addr_i    (rd_addr_i),
    .csr_vtype_o  (csr_vtype_o),
    .csr_vl_o     (csr_vl_o),
    .vill_o       (vill_o),
    .vlmax_o      (vlmax_o),
    .rd_wr_valid_o(rd_wr_valid_o),
    .rd_wr_addr_o (rd_wr_addr_o),
    .rd_wr_data_o (rd_wr_data_o),
    .rd_wr_ready_i(rd_wr_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge (caller guarantees the DUT is idle).
  task automatic issue(input logic [31:0] vt, input logic [31:0] vl, input logic [4:0] rd);
    cfg_valid_i = 1'b1;
    vtype_i     = vt;
    vl_i        = vl;
    rd_addr_i   = rd;
    step();
    cfg_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    cfg_valid_i   = 1'b0;
    vtype_i       = '0;
    vl_i          = '0;
    rd_addr_i     = '0;
    rd_wr_ready_i = 1'b0;
    step();
    step();
    total++; if (csr_vtype_o !== 32'h8000_0000) $display("FAIL reset_vtype got %h want 80000000", csr_vtype_o); else passed++;
    total++; if (csr_vl_o !== 32'd0) $display("FAIL reset_vl got %0d want 0", csr_vl_o); else passed++;
    total++; if (vill_o !== 1'b1) $display("FAIL reset_vill got %b want 1", vill_o); else passed++;
    total++; if (vlmax_o !== 32'd0) $display("FAIL reset_vlmax got %0d want 0", vlmax_o); else passed++;
    total++; if (cfg_ready_o !== 1'b1) $display("FAIL reset_ready got %b want 1", cfg_ready_o); else passed++;
    total++; if (rd_wr_valid_o !== 1'b0) $display("FAIL reset_wb_valid got %b want 0", rd_wr_valid_o); else passed++;
    reset = 1'b0;
    step();
  endtask

  task automatic test_clamp();
    total++; if (cfg_ready_o !== 1'b1) $display("FAIL clamp_ready_pre got %b want 1", cfg_ready_o); else passed++;
    issue(32'h08, 32'd40, 5'd5);
    total++; if (cfg_ready_o !== 1'b0) $display("FAIL clamp_ready_upd got %b want 0", cfg_ready_o); else passed++;
    total++; if (rd_wr_valid_o !== 1'b0) $display("FAIL clamp_wb_early got %b want 0", rd_wr_valid_o); else passed++;
    step();
    total++; if (csr_vtype_o !== 32'h08) $display("FAIL clamp_vtype got %h want 00000008", csr_vtype_o); else passed++;
    total++; if (csr_vl_o !== 32'd32) $display("FAIL clamp_vl got %0d want 32", csr_vl_o); else passed++;
    total++; if (vill_o !== 1'b0) $display("FAIL clamp_vill got %b want 0", vill_o); else passed++;
    total++; if (vlmax_o !== 32'd32) $display("FAIL clamp_vlmax got %0d want 32", vlmax_o); else passed++;
    total++; if (rd_wr_valid_o !== 1'b1) $display("FAIL clamp_wb_valid got %b want 1", rd_wr_valid_o); else passed++;
    total++; if (rd_wr_addr_o !== 5'd5) $display("FAIL clamp_wb_addr got %0d want 5", rd_wr_addr_o); else passed++;
    total++; if (rd_wr_data_o !== 32'd32) $display("FAIL clamp_wb_data got %0d want 32", rd_wr_data_o); else passed++;
    rd_wr_ready_i = 1'b1;
    step();
    rd_wr_ready_i = 1'b0;
    total++; if (rd_wr_valid_o !== 1'b0) $display("FAIL clamp_wb_drop got %b want 0", rd_wr_valid_o); else passed++;
    total++; if (rd_wr_addr_o !== 5'd0 || rd_wr_data_o !== 32'd0)
      $display("FAIL clamp_wb_idle_zero got addr %0d data %0d want 0 0", rd_wr_addr_o, rd_wr_data_o);
    else passed++;
    total++; if (cfg_ready_o !== 1'b1) $display("FAIL clamp_ready_post got %b want 1", cfg_ready_o); else passed++;
  endtask

  task automatic test_illegal(input logic [31:0] vt, input logic [4:0] rd);
    issue(vt, 32'd20, rd);
    step();
    total++; if (csr_vtype_o !== 32'h8000_0000) $display("FAIL illegal_vtype(%h) got %h want 80000000", vt, csr_vtype_o); else passed++;
    total++; if (csr_vl_o !== 32'd0) $display("FAIL illegal_vl(%h) got %0d want 0", vt, csr_vl_o); else passed++;
    total++; if (vill_o !== 1'b1) $display("FAIL illegal_vill(%h) got %b want 1", vt, vill_o); else passed++;
    total++; if (vlmax_o !== 32'd0) $display("FAIL illegal_vlmax(%h) got %0d want 0", vt, vlmax_o); else passed++;
    total++; if (rd_wr_valid_o !== 1'b1 || rd_wr_addr_o !== rd || rd_wr_data_o !== 32'd0)
      $display("FAIL illegal_wb(%h) got v%b a%0d d%0d want v1 a%0d d0", vt, rd_wr_valid_o,
               rd_wr_addr_o, rd_wr_data_o, rd);
    else passed++;
    rd_wr_ready_i = 1'b1;
    step();
    rd_wr_ready_i = 1'b0;
  endtask

  task automatic test_rd_x0(input logic [31:0] vt, input logic [31:0] vl,
                            input logic [31:0] exp_vl, input logic [31:0] exp_vlmax);
    issue(vt, vl, 5'd0);
    total++; if (cfg_ready_o !== 1'b0 || rd_wr_valid_o !== 1'b0)
      $display("FAIL x0_upd(%h) got ready %b valid %b want 0 0", vt, cfg_ready_o, rd_wr_valid_o);
    else passed++;
    step();
    total++; if (csr_vl_o !== exp_vl) $display("FAIL x0_vl(%h) got %0d want %0d", vt, csr_vl_o, exp_vl); else passed++;
    total++; if (vlmax_o !== exp_vlmax) $display("FAIL x0_vlmax(%h) got %0d want %0d", vt, vlmax_o, exp_vlmax); else passed++;
    total++; if (rd_wr_valid_o !== 1'b0) $display("FAIL x0_wb_valid(%h) got %b want 0", vt, rd_wr_valid_o); else passed++;
    total++; if (cfg_ready_o !== 1'b1) $display("FAIL x0_ready(%h) got %b want 1", vt, cfg_ready_o); else passed++;
  endtask

  task automatic test_back_to_back();
    issue(32'h10, 32'd5, 5'd9);
    step();
    // Second request waits while the write-back is back-pressured.
    cfg_valid_i = 1'b1;
    vtype_i     = 32'h00;
    vl_i        = 32'd100;
    rd_addr_i   = 5'd3;
    for (int i = 0; i < 3; i++) begin
      total++; if (rd_wr_valid_o !== 1'b1 || rd_wr_addr_o !== 5'd9 || rd_wr_data_o !== 32'd5)
        $display("FAIL bp_hold[%0d] got v%b a%0d d%0d want v1 a9 d5", i, rd_wr_valid_o,
                 rd_wr_addr_o, rd_wr_data_o);
      else passed++;
      total++; if (cfg_ready_o !== 1'b0) $display("FAIL bp_ready[%0d] got %b want 0", i, cfg_ready_o); else passed++;
      step();
    end
    total++; if (csr_vtype_o !== 32'h10 || csr_vl_o !== 32'd5)
      $display("FAIL bp_csr_hold got vtype %h vl %0d want 00000010 5", csr_vtype_o, csr_vl_o);
    else passed++;
    rd_wr_ready_i = 1'b1;
    step();
    rd_wr_ready_i = 1'b0;
    // Handshake edge: back to idle, the pending request not yet taken.
    total++; if (cfg_ready_o !== 1'b1 || rd_wr_valid_o !== 1'b0)
      $display("FAIL b2b_idle got ready %b valid %b want 1 0", cfg_ready_o, rd_wr_valid_o);
    else passed++;
    step();
    cfg_valid_i = 1'b0;
    total++; if (cfg_ready_o !== 1'b0) $display("FAIL b2b_accept got ready %b want 0", cfg_ready_o); else passed++;
    total++; if (csr_vtype_o !== 32'h10) $display("FAIL b2b_no_early got vtype %h want 00000010", csr_vtype_o); else passed++;
    step();
    total++; if (csr_vtype_o !== 32'h00 || csr_vl_o !== 32'd64 || vlmax_o !== 32'd64)
      $display("FAIL b2b_csr got vtype %h vl %0d vlmax %0d want 00000000 64 64", csr_vtype_o,
               csr_vl_o, vlmax_o);
    else passed++;
    total++; if (rd_wr_valid_o !== 1'b1 || rd_wr_addr_o !== 5'd3 || rd_wr_data_o !== 32'd64)
      $display("FAIL b2b_wb got v%b a%0d d%0d want v1 a3 d64", rd_wr_valid_o, rd_wr_addr_o, rd_wr_data_o);
    else passed++;
    rd_wr_ready_i = 1'b1;
    step();
    rd_wr_ready_i = 1'b0;
  endtask

  task automatic test_reset_in_resp();
    issue(32'h08, 32'd3, 5'd4);
    step();
    total++; if (rd_wr_valid_o !== 1'b1 || csr_vl_o !== 32'd3)
      $display("FAIL rst_resp_pre got valid %b vl %0d want 1 3", rd_wr_valid_o, csr_vl_o);
    else passed++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++; if (rd_wr_valid_o !== 1'b0 || cfg_ready_o !== 1'b1)
      $display("FAIL rst_resp_fsm got valid %b ready %b want 0 1", rd_wr_valid_o, cfg_ready_o);
    else passed++;
    total++; if (csr_vtype_o !== 32'h8000_0000 || csr_vl_o !== 32'd0 || vill_o !== 1'b1 || vlmax_o !== 32'd0)
      $display("FAIL rst_resp_csr got vtype %h vl %0d vill %b vlmax %0d want 80000000 0 1 0",
               csr_vtype_o, csr_vl_o, vill_o, vlmax_o);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_clamp();
    test_illegal(32'h1F, 5'd6);                    // SEW64 with LMUL 1/2
    test_rd_x0(32'h03, 32'd1000, 32'd512, 32'd512); // SEW8, LMUL8
    test_rd_x0(32'h05, 32'd20, 32'd8, 32'd8);       // SEW8, LMUL 1/8
    test_illegal(32'h100, 5'd7);                   // reserved bit
    test_illegal(32'h04, 5'd8);                    // reserved LMUL encoding
    test_back_to_back();
    test_reset_in_resp();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
